// File: rtl/megis_pkg.sv
// megis_pkg
// Shared types and sizes for the read word packer slice.
//   WORD_W        width of one flash channel word
//   WORDS_PER_REC words packed into one query record
//   REC_W         packed record width (WORD_W * WORDS_PER_REC)
//   NWORDS_W      width of the per-record word count
//   rec_t         one FIFO entry: packed data, valid word count, closed-by-last flag
package megis_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_PER_REC = 5;
  localparam int REC_W         = WORD_W * WORDS_PER_REC;
  localparam int NWORDS_W      = 3;

  typedef struct packed {
    logic [REC_W-1:0]    data;
    logic [NWORDS_W-1:0] nwords;
    logic                last;
  } rec_t;

endpackage

// File: rtl/rec_fifo.sv
// rec_fifo
// First-word-fall-through FIFO of packed records.
// Ports:
//   clk      in   clock, posedge
//   rst      in   asynchronous active-low reset
//   push     in   write push_rec this cycle (ignored when full)
//   push_rec in   record to write
//   pop      in   drop the head record this cycle (ignored when empty)
//   head     out  head record; while empty, the most recently popped record
//   count    out  number of stored records
//   full     out  count == DEPTH
//   empty    out  count == 0
module rec_fifo
  import megis_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  rec_t                     push_rec,
  input  logic                     pop,
  output rec_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] prev_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign prev_ptr = rd_ptr - PTR_W'(1);

  // Storage is cleared on reset so that an empty FIFO presents all-zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_rec;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // When empty, the slot just behind rd_ptr still holds the last popped record;
  // it is not rewritten until DEPTH further pushes, so the output holds its value.
  always_comb begin
    head = empty ? mem[prev_ptr] : mem[rd_ptr];
  end

endmodule

// File: rtl/read_word_packer.sv
// read_word_packer
// Packs 32-bit flash channel words into 160-bit query records of up to five
// words and hands whole records downstream through a small record FIFO.
// Ports:
//   clk        in   clock, posedge
//   rst        in   asynchronous active-low reset
//   in_valid   in   input word valid
//   in_ready   out  packer can take a word (FIFO not full, not in reset)
//   in_data    in   input word
//   in_last    in   final word of a read; closes the record early
//   out_valid  out  head record valid
//   out_ready  in   downstream takes the head record
//   out_data   out  packed record, word k at [k*32 +: 32]
//   out_nwords out  valid words in out_data (1..5)
//   out_last   out  record was closed by in_last
//   rec_count  out  records pushed since reset, wrapping
module read_word_packer
  import megis_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REC_W-1:0]    out_data,
  output logic [NWORDS_W-1:0] out_nwords,
  output logic                out_last,
  output logic [CNT_W-1:0]    rec_count
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NWORDS_W-1:0] widx;
  logic [REC_W-1:0]    asm_q;
  logic                accept;
  logic                close;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;
  rec_t                push_rec;
  rec_t                head;

  // in_ready looks only at the current fill level, so a same-cycle pop never
  // opens the input path combinationally.
  assign in_ready = rst && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign close    = accept && ((widx == NWORDS_W'(WORDS_PER_REC - 1)) || in_last);
  assign pop      = out_valid && out_ready;

  // Slots at and above widx are always zero in asm_q, so OR-ing the closing
  // word into its slot yields a record whose unused upper slots are zero.
  always_comb begin
    push_rec        = '0;
    push_rec.data   = asm_q | (REC_W'(in_data) << (widx * WORD_W));
    push_rec.nwords = widx + NWORDS_W'(1);
    push_rec.last   = in_last;
  end

  // Word index, assembly register and record counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      widx      <= '0;
      asm_q     <= '0;
      rec_count <= '0;
    end else if (accept) begin
      if (close) begin
        widx      <= '0;
        asm_q     <= '0;
        rec_count <= rec_count + CNT_W'(1);
      end else begin
        asm_q[widx*WORD_W +: WORD_W] <= in_data;
        widx                         <= widx + NWORDS_W'(1);
      end
    end
  end

  rec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (close),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = head.data;
  assign out_nwords = head.nwords;
  assign out_last   = head.last;

endmodule

// File: tb/tb_read_word_packer.sv
// tb_read_word_packer
// Directed bench for read_word_packer with a queue-based record model that is
// compared against the DUT outputs on every falling clock edge.
module tb_read_word_packer;
  import megis_pkg::*;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [REC_W-1:0]    out_data;
  logic [NWORDS_W-1:0] out_nwords;
  logic                out_last;
  logic [15:0]         rec_count;

  int total = 0;
  int bad   = 0;

  read_word_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_nwords (out_nwords),
    .out_last   (out_last),
    .rec_count  (rec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: records waiting downstream, words of the open record,
  // last record handed over, and the number of records closed.
  rec_t        exp_q [$];
  logic [31:0] part  [$];
  rec_t        m_last = '0;
  logic [15:0] m_count = '0;
  rec_t        m_head;
  rec_t        m_new;
  bit          m_rdy;
  bit          m_pop;

  task automatic checkOutput(input string name, input logic [191:0] act,
                             input logic [191:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Asynchronous reset empties everything the model tracks.
  always @(negedge rst) begin
    exp_q.delete();
    part.delete();
    m_last  = '0;
    m_count = '0;
  end

  // Model advance: pop decided from the queue before this edge's push.
  always @(posedge clk) begin
    if (rst) begin
      m_rdy = (exp_q.size() < 4);
      m_pop = (exp_q.size() > 0) && out_ready;
      if (m_pop) m_last = exp_q.pop_front();
      if (in_valid && m_rdy) begin
        part.push_back(in_data);
        if (part.size() == 5 || in_last) begin
          m_new = '0;
          foreach (part[k]) m_new.data[k*32 +: 32] = part[k];
          m_new.nwords = 3'(part.size());
          m_new.last   = in_last;
          exp_q.push_back(m_new);
          part.delete();
          m_count = m_count + 16'd1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    m_head = (exp_q.size() != 0) ? exp_q[0] : m_last;
    checkOutput("cyc_in_ready", in_ready, rst && (exp_q.size() < 4));
    checkOutput("cyc_out_valid", out_valid, exp_q.size() != 0);
    checkOutput("cyc_out_data", out_data, m_head.data);
    checkOutput("cyc_out_nwords", out_nwords, m_head.nwords);
    checkOutput("cyc_out_last", out_last, m_head.last);
    checkOutput("cyc_rec_count", rec_count, m_count);
  end

  // Offer one word and hold it until the DUT takes it; returns 1 ns after the
  // accepting edge.
  task automatic applyStimulus(input logic [31:0] w, input logic last);
    int waited = 0;
    in_data  = w;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout actual=%0d required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_rec_count", rec_count, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 1: ten words, no stalls");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(32'(i), 1'b0);
      if (i == 4) begin
        checkOutput("t1_rec0_data", out_data,
                    160'h00000004_00000003_00000002_00000001_00000000);
        checkOutput("t1_rec0_nwords", out_nwords, 5);
        checkOutput("t1_rec0_last", out_last, 0);
      end
    end
    checkOutput("t1_rec1_data", out_data,
                160'h00000009_00000008_00000007_00000006_00000005);
    checkOutput("t1_rec_count", rec_count, 2);

    $display("[TB] test 2: short record closed by in_last");
    applyStimulus(32'hA, 1'b0);
    applyStimulus(32'hB, 1'b0);
    applyStimulus(32'hC, 1'b1);
    checkOutput("t2_data", out_data,
                160'h00000000_00000000_0000000C_0000000B_0000000A);
    checkOutput("t2_nwords", out_nwords, 3);
    checkOutput("t2_last", out_last, 1);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] test 3: stalled output, 25 words");
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(32'h100 + 32'(i), 1'b0);
    checkOutput("t3_full_in_ready", in_ready, 0);
    checkOutput("t3_rec_count", rec_count, 7);
    fork
      for (int i = 20; i < 25; i++) applyStimulus(32'h100 + 32'(i), 1'b0);
      begin
        repeat (3) @(negedge clk);
        checkOutput("t3_held_in_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t3_drained_valid", out_valid, 0);
    checkOutput("t3_last_data", out_data,
                160'h00000118_00000117_00000116_00000115_00000114);
    checkOutput("t3_final_count", rec_count, 8);

    $display("[TB] test 4: push and pop in the same cycle");
    out_ready = 1'b0;
    for (int i = 0; i < 14; i++) applyStimulus(32'h400 + 32'(i), 1'b0);
    in_data   = 32'h40E;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("t4_fifo_count", dut.fifo_count, 2);
    checkOutput("t4_head_data", out_data,
                160'h00000409_00000408_00000407_00000406_00000405);
    checkOutput("t4_rec_count", rec_count, 11);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t4_drained_data", out_data,
                160'h0000040E_0000040D_0000040C_0000040B_0000040A);
    checkOutput("t4_drained_valid", out_valid, 0);

    $display("[TB] test 5: asynchronous reset mid-record");
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(32'h300 + 32'(i), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5_out_valid", out_valid, 0);
    checkOutput("t5_out_data", out_data, 0);
    checkOutput("t5_out_nwords", out_nwords, 0);
    checkOutput("t5_in_ready", in_ready, 0);
    checkOutput("t5_rec_count", rec_count, 0);
    repeat (2) @(negedge clk);
    #2;
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) applyStimulus(32'h500 + 32'(i), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5_new_data", out_data,
                160'h00000504_00000503_00000502_00000501_00000500);
    checkOutput("t5_new_count", rec_count, 1);

    $display("[TB] test 6: rec_count wrap");
    for (int i = 0; i < 65534; i++) applyStimulus(32'(i), 1'b1);
    checkOutput("t6_count_max", rec_count, 16'hFFFF);
    applyStimulus(32'hDEAD, 1'b1);
    checkOutput("t6_count_wrap", rec_count, 0);
    checkOutput("t6_wrap_data", out_data, 160'h0000DEAD);
    checkOutput("t6_wrap_nwords", out_nwords, 1);
    repeat (2) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
